// File: rtl/meta_pkg.sv
// ============================================================================
//  Module  : meta_pkg
//  Purpose : Shared colours, glyph geometry and types for the HUD timer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package meta_pkg;

    localparam logic [7:0] TEXT_COLOR = 8'hFF;
    localparam logic [7:0] WARN_COLOR = 8'hE0;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    // 0-9 are digits; the remaining codes are symbols
    typedef logic [3:0] glyph_code_t;
    localparam glyph_code_t GLYPH_COLON = 4'd10;
    localparam glyph_code_t GLYPH_BLANK = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

endpackage

`default_nettype wire

// File: rtl/meta_digit_bitmap.sv
// ============================================================================
//  Module  : meta_digit_bitmap
//  Purpose : Combinational 8x16 font ROM; bit 7 of the row is the leftmost column.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module meta_digit_bitmap
    import meta_pkg::*;
(
    input  glyph_code_t i_code,
    input  logic [3:0]  i_row,
    output logic [7:0]  o_bits
);

    // Each glyph is 16 rows packed MSB-first: row 0 is the top byte
    localparam logic [127:0] c_G0 = 128'h0000_7CC6_C6CE_DEF6_E6C6_C6C6_7C00_0000;
    localparam logic [127:0] c_G1 = 128'h0000_1838_7818_1818_1818_1818_7E00_0000;
    localparam logic [127:0] c_G2 = 128'h0000_7CC6_060C_1830_60C0_C6C6_FE00_0000;
    localparam logic [127:0] c_G3 = 128'h0000_7CC6_0606_3C06_0606_06C6_7C00_0000;
    localparam logic [127:0] c_G4 = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C0C_1E00_0000;
    localparam logic [127:0] c_G5 = 128'h0000_FEC0_C0C0_FC06_0606_06C6_7C00_0000;
    localparam logic [127:0] c_G6 = 128'h0000_3860_C0C0_FCC6_C6C6_C6C6_7C00_0000;
    localparam logic [127:0] c_G7 = 128'h0000_FEC6_0606_0C18_3030_3030_3000_0000;
    localparam logic [127:0] c_G8 = 128'h0000_7CC6_C6C6_7CC6_C6C6_C6C6_7C00_0000;
    localparam logic [127:0] c_G9 = 128'h0000_7CC6_C6C6_7E06_0606_060C_7800_0000;
    localparam logic [127:0] c_GC = 128'h0000_0000_1818_0000_0000_1818_0000_0000;

    logic [127:0] w_glyph;

    always_comb begin
        w_glyph = '0;
        case (i_code)
            4'd0:        w_glyph = c_G0;
            4'd1:        w_glyph = c_G1;
            4'd2:        w_glyph = c_G2;
            4'd3:        w_glyph = c_G3;
            4'd4:        w_glyph = c_G4;
            4'd5:        w_glyph = c_G5;
            4'd6:        w_glyph = c_G6;
            4'd7:        w_glyph = c_G7;
            4'd8:        w_glyph = c_G8;
            4'd9:        w_glyph = c_G9;
            GLYPH_COLON: w_glyph = c_GC;
            default:     w_glyph = '0;
        endcase
        // ~row == 15-row selects the byte counted from the bottom
        o_bits = w_glyph[{~i_row, 3'b000} +: 8];
    end

endmodule

`default_nettype wire

// File: rtl/meta_timer_drawer.sv
// ============================================================================
//  Module  : meta_timer_drawer
//  Purpose : M:SS countdown round timer rendered as four HUD glyphs.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module meta_timer_drawer
    import meta_pkg::*;
#(
    parameter int CLK_FREQ      = 31_500_000,
    parameter int START_SECONDS = 180,
    parameter int TOP_LEFT_X    = 280,
    parameter int TOP_LEFT_Y    = 8,
    parameter int SCALE         = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        restart,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic        timeUp
);

    localparam int c_PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX  = c_PW'(CLK_FREQ - 1);
    localparam logic [c_PW-1:0] c_PRESC_HALF = c_PW'(CLK_FREQ / 2);
    localparam logic [3:0] c_MIN0  = 4'(START_SECONDS / 60);
    localparam logic [3:0] c_TENS0 = 4'((START_SECONDS % 60) / 10);
    localparam logic [3:0] c_ONES0 = 4'(START_SECONDS % 10);
    localparam logic [10:0] c_BOX_W    = 11'(4 * GLYPH_W * SCALE);
    localparam logic [10:0] c_BOX_H    = 11'(GLYPH_H * SCALE);
    localparam logic [10:0] c_GLYPH_PX = 11'(GLYPH_W * SCALE);
    localparam logic [10:0] c_SCALE    = 11'(SCALE);

    timer_state_t    r_state, w_state_nxt;
    logic [c_PW-1:0] r_presc;
    logic [3:0]      r_min, r_sec_tens, r_sec_ones;
    logic            r_time_up;
    logic            r_draw;
    logic [7:0]      r_rgb;

    logic w_running, w_tick, w_at_one;

    assign w_running = (r_state == RUNNING) && enable;
    assign w_tick    = w_running && (r_presc == c_PRESC_MAX);
    assign w_at_one  = (r_min == 4'd0) && (r_sec_tens == 4'd0) && (r_sec_ones == 4'd1);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (restart)
            w_state_nxt = RUNNING;
        else if (w_tick && w_at_one)
            w_state_nxt = EXPIRED;
    end

    // ---------------- prescaler and BCD count ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_min      <= c_MIN0;
            r_sec_tens <= c_TENS0;
            r_sec_ones <= c_ONES0;
            r_time_up  <= 1'b0;
        end else begin
            // restart has priority, so a coincident tick never fires timeUp
            r_time_up <= !restart && w_tick && w_at_one;
            if (restart) begin
                r_presc    <= '0;
                r_min      <= c_MIN0;
                r_sec_tens <= c_TENS0;
                r_sec_ones <= c_ONES0;
            end else if (w_tick) begin
                r_presc <= '0;
                if (r_sec_ones != 4'd0) begin
                    r_sec_ones <= r_sec_ones - 4'd1;
                end else begin
                    r_sec_ones <= 4'd9;
                    if (r_sec_tens != 4'd0) begin
                        r_sec_tens <= r_sec_tens - 4'd1;
                    end else begin
                        r_sec_tens <= 4'd5;
                        r_min      <= r_min - 4'd1;
                    end
                end
            end else if (w_running) begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // ---------------- glyph addressing ----------------
    logic [10:0] w_rel_x, w_rel_y;
    logic        w_inside;
    logic [1:0]  w_gidx;
    logic [2:0]  w_col;
    logic [3:0]  w_row;
    glyph_code_t w_code;
    logic [7:0]  w_bits;

    // Pixels left of / above the box wrap to large values and fail the bound
    assign w_rel_x  = pixelX - 11'(TOP_LEFT_X);
    assign w_rel_y  = pixelY - 11'(TOP_LEFT_Y);
    assign w_inside = (w_rel_x < c_BOX_W) && (w_rel_y < c_BOX_H);
    assign w_gidx   = 2'(w_rel_x / c_GLYPH_PX);
    assign w_col    = 3'(w_rel_x / c_SCALE);
    assign w_row    = 4'(w_rel_y / c_SCALE);

    always_comb begin
        w_code = GLYPH_BLANK;
        case (w_gidx)
            2'd0: w_code = r_min;
            2'd1: w_code = GLYPH_COLON;
            2'd2: w_code = r_sec_tens;
            2'd3: w_code = r_sec_ones;
            default: w_code = GLYPH_BLANK;
        endcase
    end

    meta_digit_bitmap u_bitmap (
        .i_code (w_code),
        .i_row  (w_row),
        .o_bits (w_bits)
    );

    // ---------------- colour and output registers ----------------
    logic       w_warn, w_opaque;
    logic [7:0] w_color;

    assign w_warn   = (r_state == RUNNING) && (r_min == 4'd0) && (r_sec_tens == 4'd0);
    assign w_opaque = w_inside && w_bits[~w_col];

    always_comb begin
        w_color = TEXT_COLOR;
        if (r_state == EXPIRED)
            w_color = WARN_COLOR;
        else if (w_warn && (r_presc < c_PRESC_HALF))
            w_color = WARN_COLOR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_draw <= 1'b0;
            r_rgb  <= 8'h00;
        end else begin
            r_draw <= w_opaque;
            r_rgb  <= w_opaque ? w_color : 8'h00;
        end
    end

    assign drawingRequest = r_draw;
    assign RGBout         = r_rgb;
    assign timeUp         = r_time_up;

endmodule

`default_nettype wire

// File: tb/tb_meta_timer_drawer.sv
// ============================================================================
//  Module  : tb_meta_timer_drawer
//  Purpose : Directed self-checking bench for the HUD countdown timer.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_meta_timer_drawer;
    import meta_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable, restart;
    logic [10:0] pixelX, pixelY;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic        timeUp;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [7:0] ZERO_ROWS [16] = '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hCE, 8'hDE, 8'hF6,
                                              8'hE6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] COLON_ROWS [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00,
                                               8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] NINE_ROWS [16] = '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7E, 8'h06,
                                              8'h06, 8'h06, 8'h06, 8'h0C, 8'h78, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    meta_timer_drawer #(
        .CLK_FREQ      (10),
        .START_SECONDS (12),
        .TOP_LEFT_X    (280),
        .TOP_LEFT_Y    (8),
        .SCALE         (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .restart        (restart),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .timeUp         (timeUp)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [11:0] bcd(input int s);
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic logic [11:0] count_obs();
        return {dut.r_min, dut.r_sec_tens, dut.r_sec_ones};
    endfunction

    // One pixel per clock from x=279 to 312; output for pixel x is seen one edge later
    task automatic scan_row(input int r, input logic [7:0] col, input logic want_word,
                            input logic [31:0] exp_word);
        logic [31:0] word;
        int rgb_err;
        int edge_err;
        word = '0;
        rgb_err = 0;
        edge_err = 0;
        pixelY = 11'(8 + r);
        for (int x = 279; x <= 312; x++) begin
            pixelX = 11'(x);
            step(1);
            if (x == 279 || x == 312) begin
                if (drawingRequest || RGBout != 8'h00) edge_err++;
            end else begin
                word[311 - x] = drawingRequest;
                if (drawingRequest ? (RGBout != col) : (RGBout != 8'h00)) rgb_err++;
            end
        end
        if (want_word) check_eq($sformatf("row%0d_bits", r), word, exp_word);
        check_eq($sformatf("row%0d_rgb", r), rgb_err, 0);
        check_eq($sformatf("row%0d_edges", r), edge_err, 0);
    endtask

    initial begin
        int sec_prev, prev;
        logic [7:0] exp_rgb;

        reset = 1'b1; enable = 1'b0; restart = 1'b0;
        pixelX = '0; pixelY = '0;
        step(3);
        check_eq("rst_state", dut.r_state, IDLE);
        check_eq("rst_count", count_obs(), bcd(12));
        check_eq("rst_draw", drawingRequest, 1'b0);
        check_eq("rst_rgb", RGBout, 8'h00);
        check_eq("rst_timeup", timeUp, 1'b0);

        // opaque pixel of the minutes '0': row 2, column 1
        pixelX = 11'd281; pixelY = 11'd10;
        step(1);
        check_eq("rst_hold_draw", drawingRequest, 1'b0);
        reset = 1'b0;
        step(1);
        check_eq("idle_draw", drawingRequest, 1'b1);
        check_eq("idle_rgb", RGBout, TEXT_COLOR);

        // full countdown 0:12 -> 0:00
        enable = 1'b1; restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_eq("run_state", dut.r_state, RUNNING);
        check_eq("run_count0", count_obs(), bcd(12));
        check_eq("run_presc0", dut.r_presc, 0);
        for (int k = 1; k <= 125; k++) begin
            step(1);
            check_eq($sformatf("count_k%0d", k), count_obs(), bcd((k < 120) ? 12 - k / 10 : 0));
            check_eq($sformatf("timeup_k%0d", k), timeUp, (k == 120));
            prev = k - 1;
            sec_prev = 12 - prev / 10;
            if (prev >= 120)                        exp_rgb = WARN_COLOR;
            else if (sec_prev < 10 && prev % 10 < 5) exp_rgb = WARN_COLOR;
            else                                    exp_rgb = TEXT_COLOR;
            check_eq($sformatf("rgb_k%0d", k), RGBout, exp_rgb);
        end
        check_eq("expired_state", dut.r_state, EXPIRED);

        // restart out of EXPIRED
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_eq("rs_state", dut.r_state, RUNNING);
        check_eq("rs_count", count_obs(), bcd(12));
        check_eq("rs_timeup", timeUp, 1'b0);
        step(1);
        check_eq("rs_text_rgb", RGBout, TEXT_COLOR);

        // pause at 0:05 with prescaler 3
        step(72);
        enable = 1'b0;
        check_eq("pause_pre_count", count_obs(), bcd(5));
        check_eq("pause_pre_presc", dut.r_presc, 3);
        step(37);
        check_eq("pause_count", count_obs(), bcd(5));
        check_eq("pause_presc", dut.r_presc, 3);
        check_eq("pause_rgb_frozen", RGBout, WARN_COLOR);
        enable = 1'b1;
        step(6);
        check_eq("resume6_count", count_obs(), bcd(5));
        step(1);
        check_eq("resume7_count", count_obs(), bcd(4));
        check_eq("resume7_presc", dut.r_presc, 0);

        // restart coinciding with a tick at 0:03
        step(19);
        check_eq("coin_pre_count", count_obs(), bcd(3));
        check_eq("coin_pre_presc", dut.r_presc, 9);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_eq("coin_count", count_obs(), bcd(12));
        check_eq("coin_presc", dut.r_presc, 0);
        check_eq("coin_timeup", timeUp, 1'b0);
        step(1);
        check_eq("coin_timeup_next", timeUp, 1'b0);

        // freeze at 0:09, prescaler 2, and scan every glyph row
        step(31);
        enable = 1'b0;
        check_eq("scan_count", count_obs(), bcd(9));
        check_eq("scan_presc", dut.r_presc, 2);
        for (int r = 0; r < 16; r++)
            scan_row(r, WARN_COLOR, 1'b1, {ZERO_ROWS[r], COLON_ROWS[r], ZERO_ROWS[r], NINE_ROWS[r]});

        // second blink phase (prescaler 7)
        enable = 1'b1;
        step(5);
        enable = 1'b0;
        check_eq("phase2_presc", dut.r_presc, 7);
        scan_row(7, TEXT_COLOR, 1'b1, {ZERO_ROWS[7], COLON_ROWS[7], ZERO_ROWS[7], NINE_ROWS[7]});

        // live blink on a fixed opaque pixel
        pixelX = 11'd281; pixelY = 11'd10;
        enable = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step(1);
            check_eq($sformatf("blink_j%0d", j), RGBout,
                     (((7 + j - 1) % 10) < 5) ? WARN_COLOR : TEXT_COLOR);
        end

        // tens digit non-zero: no warning colour on any opaque pixel
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        enable = 1'b0;
        step(2);
        scan_row(3, TEXT_COLOR, 1'b0, 32'h0);

        // asynchronous reset mid-count at 0:07
        pixelX = 11'd281; pixelY = 11'd10;
        enable = 1'b1;
        step(50);
        check_eq("mid_pre_count", count_obs(), bcd(7));
        check_eq("mid_pre_draw", drawingRequest, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("mid_async_draw", drawingRequest, 1'b0);
        check_eq("mid_async_count", count_obs(), bcd(12));
        step(1);
        check_eq("mid_state", dut.r_state, IDLE);
        check_eq("mid_count", count_obs(), bcd(12));
        check_eq("mid_draw", drawingRequest, 1'b0);
        check_eq("mid_rgb", RGBout, 8'h00);
        check_eq("mid_timeup", timeUp, 1'b0);
        reset = 1'b0;
        step(1);
        check_eq("post_rst_draw", drawingRequest, 1'b1);
        check_eq("post_rst_rgb", RGBout, TEXT_COLOR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
